// File: rtl/clock_expt_pkg.sv
// Shared constants and types for the elapsed-time clock.
// CLOCK_EXPT_FAST_SIM_EN shortens one "second" to 1000 cycles for simulation.
package clock_expt_pkg;
    localparam int CNT_W   = 27;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 3;
`ifdef CLOCK_EXPT_FAST_SIM_EN
    localparam int DIV     = 1000;
`else
    localparam int DIV     = 125_000_000;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;
endpackage

// File: rtl/clock_expt_prescaler.sv
// Divides the fabric clock by DIV.
// Produces a one-cycle sec_tick on wrap and a 50% duty 1 Hz time base.
module clock_expt_prescaler
    import clock_expt_pkg::*;
#(
    parameter int DIV = 1000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_counter,
    output logic             o_sec_tick,
    output logic             o_clk_1Hz
);
    logic [CNT_W-1:0] r_counter;
    logic             r_clk_1Hz;
    logic             w_wrap;
    logic [CNT_W-1:0] w_next;

    assign w_wrap     = (r_counter == CNT_W'(DIV - 1));
    assign w_next     = w_wrap ? '0 : r_counter + 1'b1;
    assign o_sec_tick = i_en & w_wrap;

    // The half-period flag is computed from the next count so clk_1Hz is
    // high exactly while counter sits in the upper half of the second.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_counter <= '0;
            r_clk_1Hz <= 1'b0;
        end else if (i_en) begin
            r_counter <= w_next;
            r_clk_1Hz <= (w_next >= CNT_W'(DIV / 2));
        end
    end

    assign o_counter = r_counter;
    assign o_clk_1Hz = r_clk_1Hz;
endmodule

// File: rtl/clock_expt.sv
// Elapsed-time clock: run/stop control, seconds (0-59), minutes (0-3), sticky done at 3:59.
// Build option: CLOCK_EXPT_FAST_SIM_EN selects a 1000-cycle second.
module clock_expt
    import clock_expt_pkg::*;
#(
    parameter int CLK_HZ = 125_000_000
) (
    input  logic             clk_125MHz,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    output logic             clk_1Hz,
    output logic [1:0]       min,
    output logic             done,
    output logic [CNT_W-1:0] counter,
    output logic [5:0]       count
);
`ifdef CLOCK_EXPT_FAST_SIM_EN
    localparam int DIV_EFF = DIV;
`else
    localparam int DIV_EFF = CLK_HZ;
`endif

    run_state_t r_state, w_state_nxt;
    logic [5:0] r_count;
    logic [1:0] r_min;
    logic       r_done;
    logic       w_en;
    logic       w_tick;

    always_ff @(posedge clk_125MHz or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // stop wins over start; once done is set start no longer re-arms the run
    always_comb begin
        w_state_nxt = r_state;
        if (stop)                  w_state_nxt = ST_IDLE;
        else if (start && !r_done) w_state_nxt = ST_RUN;
    end

    assign w_en = (r_state == ST_RUN) & ~r_done;

    clock_expt_prescaler #(.DIV(DIV_EFF)) u_prescaler (
        .i_clk      (clk_125MHz),
        .i_rst_n    (rst),
        .i_en       (w_en),
        .o_counter  (counter),
        .o_sec_tick (w_tick),
        .o_clk_1Hz  (clk_1Hz)
    );

    always_ff @(posedge clk_125MHz or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_min   <= '0;
            r_done  <= 1'b0;
        end else if (w_tick) begin
            if (r_count == 6'(SEC_MAX)) begin
                r_count <= '0;
                if (r_min != 2'(MIN_MAX)) r_min <= r_min + 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
            // done lands on the same edge that shows 3:59
            if (r_min == 2'(MIN_MAX) && r_count == 6'(SEC_MAX - 1))
                r_done <= 1'b1;
        end
    end

    assign count = r_count;
    assign min   = r_min;
    assign done  = r_done;
endmodule

// File: tb/tb_clock_expt.sv
// Directed bench for clock_expt; runs with a short second to keep the limit test brief.
module tb_clock_expt;
    localparam int CLK_HZ = 100;
`ifdef CLOCK_EXPT_FAST_SIM_EN
    localparam int D = 1000;
`else
    localparam int D = CLK_HZ;
`endif

    logic        clk_125MHz = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clk_1Hz;
    logic [1:0]  min;
    logic        done;
    logic [26:0] counter;
    logic [5:0]  count;

    int total = 0;
    int fails = 0;

    clock_expt #(.CLK_HZ(CLK_HZ)) dut (
        .clk_125MHz (clk_125MHz),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .clk_1Hz    (clk_1Hz),
        .min        (min),
        .done       (done),
        .counter    (counter),
        .count      (count)
    );

    always #4 clk_125MHz = ~clk_125MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_125MHz);
    endtask

    task automatic chk_all(input string tag, input int e_ctr, input int e_clk,
                           input int e_sec, input int e_min, input int e_done);
        chk({tag, ".counter"}, 32'(counter), 32'(e_ctr));
        chk({tag, ".clk_1Hz"}, 32'(clk_1Hz), 32'(e_clk));
        chk({tag, ".count"},   32'(count),   32'(e_sec));
        chk({tag, ".min"},     32'(min),     32'(e_min));
        chk({tag, ".done"},    32'(done),    32'(e_done));
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    initial begin
        // reset state
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        step(3);
        rst = 1'b1;
        step(2);
        chk_all("idle", 0, 0, 0, 0, 0);

        // first second: counter ramps one edge after start is sampled
        start = 1'b1;
        step(1);
        chk("first.ctr0", 32'(counter), 0);
        for (int k = 1; k <= D; k++) begin
            step(1);
            chk("ramp.counter", 32'(counter), 32'(k % D));
            chk("ramp.clk_1Hz", 32'(clk_1Hz), 32'((k % D) >= D / 2));
            if (k == D - 1) chk("ramp.count_pre", 32'(count), 0);
        end
        chk_all("sec1", 0, 0, 1, 0, 0);

        // minute rollover at 60*D+1 edges from start
        step(59 * D - 1);
        chk_all("pre_min", D - 1, 1, 59, 0, 0);
        step(1);
        chk_all("min1", 0, 0, 0, 1, 0);

        // limit at 239*D+1 edges
        step(179 * D - 1);
        chk_all("pre_lim", D - 1, 1, 58, 3, 0);
        step(1);
        chk_all("limit", 0, 0, 59, 3, 1);
        step(5000);
        chk_all("frozen", 0, 0, 59, 3, 1);

        // stop mid-second holds the count; resuming finishes the second
        do_reset();
        start = 1'b1;
        step(40);
        chk("stop.pre", 32'(counter), 39);
        stop = 1'b1;
        step(1);
        chk("stop.at", 32'(counter), 40);
        step(200);
        chk_all("stopped", 40, 0, 0, 0, 0);
        stop = 1'b0;
        step(D - 40);
        chk("resume.pre_ctr", 32'(counter), 32'(D - 1));
        chk("resume.pre_sec", 32'(count), 0);
        step(1);
        chk_all("resume.sec1", 0, 0, 1, 0, 0);

        // start and stop together never run
        do_reset();
        start = 1'b1; stop = 1'b1;
        step(50);
        chk_all("both", 0, 0, 0, 0, 0);

        // async reset mid-count
        do_reset();
        start = 1'b1;
        step(137 * D + 1);
        chk_all("t2_17", 0, 0, 17, 2, 0);
        step(D / 2 + 3);
        chk("t2_17.clk", 32'(clk_1Hz), 1);
        #1 rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        step(3);
        rst = 1'b1;
        start = 1'b0;
        step(20);
        chk_all("post_rst", 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
